// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp: parametrised dual-port on-chip RAM with two Avalon-MM slave ports
// (s1, s2) on one clock.
//
// Features: byte-lane writes, pipelined reads (READ_LATENCY 1 or 2) qualified by
// readdatavalid, s1-priority per-lane write collisions, cross-port write-first
// read-during-write, and an optional post-reset zero-fill engine.
//
// Ports (sN = s1, s2; identical sets):
//   clk                single clock
//   reset              asynchronous, active-high
//   sN_address         word address (ADDR_W)
//   sN_chipselect      port select
//   sN_read            read request
//   sN_write           write request (wins over a simultaneous read on the same port)
//   sN_byteenable      write byte lanes (DATA_W/8)
//   sN_writedata       write data
//   sN_readdata        read data, holds its value between valid pulses
//   sN_readdatavalid   one-cycle pulse qualifying readdata
//   sN_waitrequest     stall, high only during reset/clear
//   init_done          RAM ready for traffic
module onchip_memory_dp #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter string       INIT_FILE      = "onchip_memory_dp.hex"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  output logic                  init_done
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StClear, StReady} state_e;

  // Power-up contents come from the device configuration image, not from reset.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  state_e           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             wait_q;

  // Per-port request signals, index 0 = s1, index 1 = s2.
  logic [ADDR_W-1:0] addr   [2];
  logic [IDX_W-1:0]  idx    [2];
  logic [BE_W-1:0]   be     [2];
  logic [DATA_W-1:0] wdata  [2];
  logic [DATA_W-1:0] nxt    [2];
  logic [DATA_W-1:0] rd_out [2];
  logic [1:0]        cs, rd, wr, in_range, wr_en, rd_acc, rv_out;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign cs       = {s2_chipselect, s1_chipselect};
  assign rd       = {s2_read, s1_read};
  assign wr       = {s2_write, s1_write};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]      = addr[p][IDX_W-1:0];
      in_range[p] = 32'(addr[p]) < DEPTH;
      // Out-of-range writes are dropped; a read alongside a write on one port is dropped.
      wr_en[p]    = cs[p] & wr[p] & ~wait_q & in_range[p];
      rd_acc[p]   = cs[p] & rd[p] & ~wr[p] & ~wait_q;
    end
  end

  // Word as it will look after this cycle's writes, at each port's address. s2 lanes
  // are applied first so s1 overrides on shared lanes. The same value feeds both the
  // RAM write and the cross-port write-first read bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      nxt[p] = mem[idx[p]];
      for (int q = 1; q >= 0; q--) begin
        if (wr_en[q] && (idx[q] == idx[p])) begin
          for (int i = 0; i < BE_W; i++) begin
            if (be[q][i]) nxt[p][8*i +: 8] = wdata[q][8*i +: 8];
          end
        end
      end
    end
  end

  // RAM array: not reset, so contents survive reset unless the clear engine runs.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_en[0]) mem[idx[0]] <= nxt[0];
      if (wr_en[1]) mem[idx[1]] <= nxt[1];
    end
  end

  // Clear / ready sequencer. Idle spends one cycle after reset release, then Clear
  // zeroes one word per cycle; init_done and the waitrequest drop arrive together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      wait_q    <= CLEAR_ON_RESET;
      init_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CLEAR_ON_RESET) begin
            state_q <= StClear;
          end else begin
            state_q   <= StReady;
            wait_q    <= 1'b0;
            init_done <= 1'b1;
          end
        end
        StClear: begin
          if (clr_cnt_q == LastIdx) begin
            state_q   <= StReady;
            wait_q    <= 1'b0;
            init_done <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          end
        end
        StReady: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read pipeline per port: stage 0 captures the word at acceptance, later stages
  // only add latency. Data registers load only with valid, so readdata holds.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [READ_LATENCY-1:0][DATA_W-1:0] data_q;
    logic [READ_LATENCY-1:0]             valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        valid_q[0] <= rd_acc[p];
        if (rd_acc[p]) data_q[0] <= in_range[p] ? nxt[p] : '0;
        for (int s = 1; s < READ_LATENCY; s++) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end

    assign rd_out[p] = data_q[READ_LATENCY-1];
    assign rv_out[p] = valid_q[READ_LATENCY-1];
  end

  assign s1_readdata      = rd_out[0];
  assign s2_readdata      = rd_out[1];
  assign s1_readdatavalid = rv_out[0];
  assign s2_readdatavalid = rv_out[1];
  assign s1_waitrequest   = wait_q;
  assign s2_waitrequest   = wait_q;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Self-checking bench for onchip_memory_dp (DEPTH=16, READ_LATENCY=2, clear on reset).
// Reads are scored against a byte-lane reference model through per-port queues that
// also carry the cycle in which readdatavalid must appear.
module tb_onchip_memory_dp;

  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] data;
    int          due;
    int          id;
  } exp_t;

  logic        clk, reset;
  logic [4:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic        init_done;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          id_cnt = 0;
  logic [31:0] model [DEPTH];
  exp_t        q1[$];
  exp_t        q2[$];

  onchip_memory_dp #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1),
    .INIT_FILE("onchip_memory_dp.hex")
  ) dut (
    .clk(clk), .reset(reset),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic mon_port(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    int   n;
    n = (p == 0) ? q1.size() : q2.size();
    e = '0;
    if (n > 0) e = (p == 0) ? q1[0] : q2[0];
    if (v === 1'b1) begin
      if (n > 0) begin
        if (p == 0) void'(q1.pop_front()); else void'(q2.pop_front());
        chk($sformatf("s%0d read#%0d data", p + 1, e.id), d, e.data);
        chk($sformatf("s%0d read#%0d cycle", p + 1, e.id), 32'(cyc), 32'(e.due));
      end else begin
        chk($sformatf("s%0d unexpected readdatavalid", p + 1), {31'b0, v}, 32'h0);
      end
    end else if (n > 0 && cyc >= e.due) begin
      if (p == 0) void'(q1.pop_front()); else void'(q2.pop_front());
      chk($sformatf("s%0d read#%0d readdatavalid", p + 1, e.id), {31'b0, v}, 32'h1);
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, s1_readdatavalid, s1_readdata);
    mon_port(1, s2_readdatavalid, s2_readdata);
  end

  task automatic idle_all();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
    s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
    s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic model_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (a < 5'(DEPTH)) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[a[3:0]][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic push(input int p, input logic [4:0] a);
    exp_t e;
    e.data = (a < 5'(DEPTH)) ? model[a[3:0]] : 32'h0;
    e.due  = cyc + LAT;
    e.id   = id_cnt++;
    if (p == 0) q1.push_back(e); else q2.push_back(e);
  endtask

  // op: 0 idle, 1 read, 2 write, 3 read+write (illegal: write only, read dropped).
  task automatic do_cycle(input int op1, input logic [4:0] a1, input logic [3:0] be1,
                          input logic [31:0] wd1, input int op2, input logic [4:0] a2,
                          input logic [3:0] be2, input logic [31:0] wd2);
    s1_chipselect = (op1 != 0); s1_read = op1[0]; s1_write = op1[1];
    s1_address = a1; s1_byteenable = be1; s1_writedata = wd1;
    s2_chipselect = (op2 != 0); s2_read = op2[0]; s2_write = op2[1];
    s2_address = a2; s2_byteenable = be2; s2_writedata = wd2;
    // s2 first so s1 owns shared lanes on a same-address collision.
    if (op2[1]) model_wr(a2, be2, wd2);
    if (op1[1]) model_wr(a1, be1, wd1);
    if (op1 == 1) push(0, a1);
    if (op2 == 1) push(1, a2);
    @(negedge clk);
    idle_all();
  endtask

  // Called at the negedge where reset has just been released.
  task automatic wait_clear(input string tag);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(negedge clk);
      chk($sformatf("%s init_done@%0d", tag, k), {31'b0, init_done}, {31'b0, k == DEPTH + 1});
      chk($sformatf("%s s1_waitrequest@%0d", tag, k), {31'b0, s1_waitrequest},
          {31'b0, k <= DEPTH});
      chk($sformatf("%s s2_waitrequest@%0d", tag, k), {31'b0, s2_waitrequest},
          {31'b0, k <= DEPTH});
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " s1_readdata"}, s1_readdata, 32'h0);
    chk({tag, " s2_readdata"}, s2_readdata, 32'h0);
    chk({tag, " s1_readdatavalid"}, {31'b0, s1_readdatavalid}, 32'h0);
    chk({tag, " s2_readdatavalid"}, {31'b0, s2_readdatavalid}, 32'h0);
    chk({tag, " init_done"}, {31'b0, init_done}, 32'h0);
    chk({tag, " s1_waitrequest"}, {31'b0, s1_waitrequest}, 32'h1);
    chk({tag, " s2_waitrequest"}, {31'b0, s2_waitrequest}, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_clear("clear1");

    // Whole RAM reads back zero on both ports, opposite address orders.
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 5'(i), 4'h0, 0, 1, 5'(DEPTH - 1 - i), 4'h0, 0);

    // Byte-lane merge on address 5: expect 0xAA22CC44 on s2.
    do_cycle(2, 5'd5, 4'b1111, 32'hAABBCCDD, 0, 5'd0, 4'h0, 0);
    do_cycle(2, 5'd5, 4'b0101, 32'h11223344, 0, 5'd0, 4'h0, 0);
    do_cycle(0, 5'd0, 4'h0, 0, 1, 5'd5, 4'h0, 0);

    // Collision on address 7: expect 0x00221111.
    do_cycle(2, 5'd7, 4'b0011, 32'h11111111, 2, 5'd7, 4'b0110, 32'h22222222);
    do_cycle(1, 5'd7, 4'h0, 0, 1, 5'd7, 4'h0, 0);

    // Cross-port read-during-write on address 3: s2 sees 0xDEADBEEF.
    do_cycle(2, 5'd3, 4'b1111, 32'hDEADBEEF, 1, 5'd3, 4'h0, 0);

    // Back-to-back reads 0..3 on s1.
    for (int i = 0; i < 4; i++) do_cycle(1, 5'(i), 4'h0, 0, 0, 5'd0, 4'h0, 0);

    // Address DEPTH: write discarded, read returns 0, address 0 untouched.
    do_cycle(2, 5'd16, 4'b1111, 32'hFFFFFFFF, 1, 5'd16, 4'h0, 0);
    do_cycle(1, 5'd0, 4'h0, 0, 1, 5'd16, 4'h0, 0);

    // Read+write on one port: write only, no readdatavalid.
    do_cycle(0, 5'd0, 4'h0, 0, 3, 5'd9, 4'b1111, 32'h5A5A1234);
    do_cycle(1, 5'd9, 4'h0, 0, 0, 5'd0, 4'h0, 0);

    // Mixed random traffic, including out-of-range and collisions.
    for (int n = 0; n < 60; n++) begin
      do_cycle(int'($urandom_range(0, 3)), 5'($urandom_range(0, 16)), 4'($urandom),
               $urandom, int'($urandom_range(0, 3)), 5'($urandom_range(0, 16)),
               4'($urandom), $urandom);
    end

    // Fill RAM with non-zero data so the next clear is observable.
    for (int i = 0; i < DEPTH; i++) do_cycle(2, 5'(i), 4'hF, 32'hA5A50000 | i, 0, 5'd0, 4'h0, 0);

    // Reset with reads in flight: they must vanish.
    do_cycle(1, 5'd3, 4'h0, 0, 1, 5'd4, 4'h0, 0);
    reset = 1'b1;
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("inflight reset");
    reset = 1'b0;

    // Abort the clear when it is at address 8, then let it restart.
    repeat (9) @(negedge clk);
    chk("midclear s1_waitrequest", {31'b0, s1_waitrequest}, 32'h1);
    chk("midclear init_done", {31'b0, init_done}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midclear reset");
    reset = 1'b0;
    wait_clear("clear2");
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 5'(i), 4'h0, 0, 1, 5'(i), 4'h0, 0);

    repeat (LAT + 3) @(negedge clk);
    chk("s1 reads outstanding", 32'(q1.size()), 32'h0);
    chk("s2 reads outstanding", 32'(q2.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
